// File: rtl/nbit_serial_adder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : nbit_serial_adder
//  Purpose  : Multi-cycle WIDTH-bit adder/subtractor. Each clock adds DIGIT
//             bits through a DIGIT-long full-adder chain. The carry between
//             digits is held in a register. Operands arrive on a valid/ready
//             handshake and results leave on a second valid/ready handshake.
//  Ports    : clk        - rising-edge clock
//             rst_n      - asynchronous active-low reset
//             in_valid   - operands valid
//             in_ready   - block can accept operands (IDLE only)
//             a, b       - WIDTH-bit operands
//             c_in       - carry-in (add) / borrow-in (sub)
//             sub        - 0: a+b+c_in, 1: a-b-c_in
//             out_valid  - result valid (DONE)
//             out_ready  - consumer takes the result
//             s          - sum/difference modulo 2^WIDTH
//             c_out      - raw carry out of the top bit (sub: 1 = no borrow)
//             ovf        - two's-complement signed overflow
//  Revision : 1.0 - initial release
// ============================================================================
module nbit_serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int c_num_digits = WIDTH / DIGIT;
  localparam int c_cnt_w      = (c_num_digits > 1) ? $clog2(c_num_digits) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_num_digits - 1);

  generate
    if ((WIDTH < 2) || (DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
      $error("nbit_serial_adder: need WIDTH>=2, 1<=DIGIT<=WIDTH and WIDTH%%DIGIT==0");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;      // b, already inverted for subtraction
  logic                 r_carry;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [WIDTH-1:0]     r_s;
  logic                 r_c_out;
  logic                 r_ovf;

  int                   w_base;
  logic [DIGIT-1:0]     w_a_dig;
  logic [DIGIT-1:0]     w_b_dig;
  logic [DIGIT-1:0]     w_sum_dig;
  logic [DIGIT:0]       w_chain;  // ripple carries; top bit is the digit carry-out
  logic [WIDTH-1:0]     w_s_next;
  logic                 w_ovf_next;

  // --------------------------------------------------------------------------
  // Digit select
  // --------------------------------------------------------------------------
  always_comb begin
    w_base  = int'(r_cnt) * DIGIT;
    w_a_dig = r_a[w_base +: DIGIT];
    w_b_dig = r_b[w_base +: DIGIT];
  end

  // --------------------------------------------------------------------------
  // DIGIT-long full-adder chain; {w_chain[DIGIT], w_sum_dig} is the
  // DIGIT+1-bit digit sum.
  // --------------------------------------------------------------------------
  assign w_chain[0] = r_carry;

  generate
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
      assign w_sum_dig[gi]  = w_a_dig[gi] ^ w_b_dig[gi] ^ w_chain[gi];
      assign w_chain[gi+1]  = (w_a_dig[gi] & w_b_dig[gi]) |
                              (w_chain[gi] & (w_a_dig[gi] ^ w_b_dig[gi]));
    end
  endgenerate

  // Sum vector with the current digit merged in. On the last digit this is
  // the final result, so overflow is judged on it rather than on r_s.
  always_comb begin
    w_s_next                  = r_s;
    w_s_next[w_base +: DIGIT] = w_sum_dig;
    w_ovf_next = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_s_next[WIDTH-1] != r_a[WIDTH-1]);
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)        w_state_next = S_ADD;
      S_ADD:   if (r_cnt == c_last) w_state_next = S_DONE;
      S_DONE:  if (out_ready)       w_state_next = S_IDLE;
      default:                      w_state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_c_out <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            // Subtraction is a + ~b + 1 - borrow, so the initial carry is ~c_in.
            r_carry <= c_in ^ sub;
            r_cnt   <= '0;
          end
        end
        S_ADD: begin
          r_s     <= w_s_next;
          r_carry <= w_chain[DIGIT];
          // Wrap to zero instead of running past the last digit, so the
          // digit select never points outside the operand.
          r_cnt   <= (r_cnt == c_last) ? '0 : r_cnt + c_cnt_w'(1);
          if (r_cnt == c_last) begin
            r_c_out <= w_chain[DIGIT];
            r_ovf   <= w_ovf_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // in_ready is gated by rst_n so it reads 0 for the whole reset assertion.
  assign in_ready  = (r_state == S_IDLE) && rst_n;
  assign out_valid = (r_state == S_DONE);
  assign s         = r_s;
  assign c_out     = r_c_out;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_nbit_serial_adder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_nbit_serial_adder
//  Purpose  : Self-checking bench for nbit_serial_adder. One directed
//             WIDTH=8/DIGIT=2 instance plus random sweep instances at other
//             WIDTH/DIGIT settings, all checked against an arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nbit_serial_adder;

  localparam int NCFG = 5;

  typedef struct {
    int s;
    bit co;
    bit ov;
    int acc;
  } exp_t;

  logic clk = 1'b0;
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  function automatic int cfg_w(input int i);
    return (i == 4) ? 16 : 8;
  endfunction

  function automatic int cfg_d(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      2:       return 4;
      3:       return 8;
      default: return 4;
    endcase
  endfunction

  // Result from plain integer arithmetic: unsigned sum for s/c_out,
  // signed-range test for overflow.
  function automatic exp_t model(input int w, input int ia, input int ib, input bit isub, input bit icin);
    exp_t e;
    int   mask, half, full, sa, sb, sr;
    mask  = (1 << w) - 1;
    half  = 1 << (w - 1);
    full  = isub ? ia + ((~ib) & mask) + (icin ? 0 : 1) : ia + ib + int'(icin);
    e.s   = full & mask;
    e.co  = ((full >> w) & 1) != 0;
    sa    = (ia >= half) ? ia - (1 << w) : ia;
    sb    = (ib >= half) ? ib - (1 << w) : ib;
    sr    = isub ? sa - sb - int'(icin) : sa + sb + int'(icin);
    e.ov  = (sr > half - 1) || (sr < -half);
    e.acc = 0;
    return e;
  endfunction

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  generate
    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
      localparam int W = cfg_w(gi);
      localparam int D = cfg_d(gi);
      localparam int K = W / D;

      logic         rst_n;
      logic         in_valid;
      logic         in_ready;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         c_in;
      logic         sub;
      logic         out_valid;
      logic         out_ready;
      logic [W-1:0] s;
      logic         c_out;
      logic         ovf;

      nbit_serial_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .c_out     (c_out),
        .ovf       (ovf)
      );

      exp_t q[$];
      int   cyc          = 0;
      int   acc_total    = 0;
      int   last_acc     = 0;
      int   last_lat_acc = -1;
      bit   b2b          = 1'b0;
      bit   prev_b2b     = 1'b0;

      // Scoreboard update at the active edge: push on accept, pop on transfer.
      always @(posedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
          q.delete();
        end else begin
          if (out_valid && out_ready && (q.size() > 0)) q.delete(0);
          if (in_valid && in_ready) begin
            e     = model(W, int'(a), int'(b), sub, c_in);
            e.acc = cyc;
            q.push_back(e);
            if (b2b && prev_b2b) check($sformatf("cfg%0d_b2b_gap", gi), cyc - last_acc, K + 2);
            prev_b2b = b2b;
            last_acc = cyc;
            acc_total++;
          end
        end
      end

      // Compare on every cycle a result is presented.
      always @(negedge clk) begin
        if (rst_n && out_valid) begin
          if (q.size() == 0) begin
            check($sformatf("cfg%0d_spurious_valid", gi), 1, 0);
          end else begin
            check($sformatf("cfg%0d_s", gi), int'(s), q[0].s);
            check($sformatf("cfg%0d_c_out", gi), int'(c_out), int'(q[0].co));
            check($sformatf("cfg%0d_ovf", gi), int'(ovf), int'(q[0].ov));
            check($sformatf("cfg%0d_in_ready_done", gi), int'(in_ready), 0);
            if (q[0].acc != last_lat_acc) begin
              check($sformatf("cfg%0d_latency", gi), cyc - q[0].acc, K);
              last_lat_acc = q[0].acc;
            end
          end
        end
      end

      task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input bit tsub, input bit tcin,
                           input int hold, output int rs, output bit rc, output bit ro, output int lat);
        int n;
        rs = 0; rc = 1'b0; ro = 1'b0; lat = -1;
        @(negedge clk);
        a = ta; b = tb_; sub = tsub; c_in = tcin; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin
          @(negedge clk);
          n++;
        end
        if (!in_ready) begin
          check($sformatf("cfg%0d_accept_timeout", gi), 0, 1);
          in_valid = 1'b0;
          return;
        end
        @(posedge clk);
        #1;
        // Scramble operands after the accept edge; they must not matter.
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom); c_in = 1'($urandom);
        lat = 0;
        do begin
          @(posedge clk);
          lat++;
          @(negedge clk);
        end while (!out_valid && lat < 100);
        if (!out_valid) begin
          check($sformatf("cfg%0d_valid_timeout", gi), 0, 1);
          return;
        end
        rs = int'(s); rc = c_out; ro = ovf;
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
      endtask

      if (gi == 0) begin : g_directed
        initial begin
          int rs, lat, n, base_acc;
          bit rc, ro;
          rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
          a = '0; b = '0; sub = 1'b0; c_in = 1'b0;
          repeat (3) @(negedge clk);
          check("rst_in_ready", int'(in_ready), 0);
          check("rst_out_valid", int'(out_valid), 0);
          check("rst_s", int'(s), 0);
          check("rst_c_out", int'(c_out), 0);
          check("rst_ovf", int'(ovf), 0);
          rst_n = 1'b1;
          @(negedge clk);
          check("idle_in_ready", int'(in_ready), 1);

          do_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, rs, rc, ro, lat);
          check("t1_latency", lat, 4);
          check("t1_s", rs, 'h00); check("t1_c_out", int'(rc), 1); check("t1_ovf", int'(ro), 0);

          do_op(8'h7F, 8'h01, 1'b0, 1'b0, 1, rs, rc, ro, lat);
          check("t2_s", rs, 'h80); check("t2_c_out", int'(rc), 0); check("t2_ovf", int'(ro), 1);

          do_op(8'h05, 8'h07, 1'b1, 1'b0, 0, rs, rc, ro, lat);
          check("t3_s", rs, 'hFE); check("t3_c_out", int'(rc), 0); check("t3_ovf", int'(ro), 0);

          do_op(8'h80, 8'h01, 1'b1, 1'b0, 0, rs, rc, ro, lat);
          check("t4_s", rs, 'h7F); check("t4_c_out", int'(rc), 1); check("t4_ovf", int'(ro), 1);

          // Backpressure: 0x3C + 0x5A = 0x96, signed overflow, no carry.
          @(negedge clk);
          a = 8'h3C; b = 8'h5A; sub = 1'b0; c_in = 1'b0; in_valid = 1'b1;
          check("bp_in_ready", int'(in_ready), 1);
          @(posedge clk);
          #1;
          in_valid = 1'b0;
          n = 0;
          while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
          end
          check("bp_reached_done", int'(out_valid), 1);
          base_acc = acc_total;
          for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid = ~in_valid;
            a = W'($urandom); b = W'($urandom);
            @(negedge clk);
            check("bp_in_ready_low", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_s", int'(s), 'h96);
            check("bp_c_out", int'(c_out), 0);
            check("bp_ovf", int'(ovf), 1);
          end
          check("bp_no_accept", acc_total, base_acc);
          in_valid = 1'b0;
          out_ready = 1'b1;
          @(posedge clk);
          #1;
          check("bp_release_in_ready", int'(in_ready), 1);
          check("bp_release_out_valid", int'(out_valid), 0);
          out_ready = 1'b0;

          // Reset asserted during the second ADD cycle.
          @(negedge clk);
          a = 8'hA5; b = 8'h3C; sub = 1'b0; c_in = 1'b0; in_valid = 1'b1;
          @(posedge clk);
          #1;
          in_valid = 1'b0;
          @(posedge clk);
          #1;
          rst_n = 1'b0;
          #1;
          check("rstmid_out_valid", int'(out_valid), 0);
          check("rstmid_in_ready", int'(in_ready), 0);
          check("rstmid_s", int'(s), 0);
          check("rstmid_c_out", int'(c_out), 0);
          check("rstmid_ovf", int'(ovf), 0);
          repeat (2) @(negedge clk);
          rst_n = 1'b1;
          @(negedge clk);
          do_op(8'h12, 8'h34, 1'b0, 1'b0, 0, rs, rc, ro, lat);
          check("t5_s", rs, 'h46); check("t5_c_out", int'(rc), 0); check("t5_latency", lat, 4);

          for (int i = 0; i < 1000; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, rs, rc, ro, lat);
          end

          // Back-to-back traffic, out_ready held high: accept every K+2 cycles.
          @(negedge clk);
          base_acc  = acc_total;
          b2b       = 1'b1;
          out_ready = 1'b1;
          in_valid  = 1'b1;
          for (int i = 0; i < 60; i++) begin
            a = W'($urandom); b = W'($urandom); sub = 1'($urandom); c_in = 1'($urandom);
            @(negedge clk);
          end
          in_valid = 1'b0;
          repeat (10) @(negedge clk);
          out_ready = 1'b0;
          b2b       = 1'b0;
          check("b2b_accepts", acc_total - base_acc, 10);
          check("b2b_drained", q.size(), 0);
          done_cnt++;
        end
      end else begin : g_random
        initial begin
          int rs, lat;
          bit rc, ro;
          rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
          a = '0; b = '0; sub = 1'b0; c_in = 1'b0;
          repeat (3) @(negedge clk);
          rst_n = 1'b1;
          for (int i = 0; i < 1000; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, rs, rc, ro, lat);
          end
          repeat (3) @(negedge clk);
          check($sformatf("cfg%0d_drained", gi), q.size(), 0);
          done_cnt++;
        end
      end
    end
  endgenerate

  initial begin
    exp_t e;
    // Hand-computed anchors for the model itself.
    e = model(8, 'hFF, 'h01, 1'b0, 1'b0);
    check("model_add_wrap_s", e.s, 'h00); check("model_add_wrap_c", int'(e.co), 1);
    e = model(8, 'h7F, 'h01, 1'b0, 1'b0);
    check("model_add_ovf", int'(e.ov), 1);
    e = model(8, 'h80, 'h01, 1'b1, 1'b0);
    check("model_sub_s", e.s, 'h7F); check("model_sub_ovf", int'(e.ov), 1);
    e = model(16, 'h1234, 'h0FFF, 1'b1, 1'b1);
    check("model_sub16_s", e.s, 'h0234); check("model_sub16_c", int'(e.co), 1);

    for (int t = 0; t < 60000 && done_cnt < NCFG; t++) @(posedge clk);
    check("all_configs_finished", done_cnt, NCFG);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
